// File: rtl/uart_rx_cmd_if.sv
// Host-link receive bundle: the serial pad in, decoded bytes and strobes out.
interface uart_rx_cmd_if;
  logic       i_rx_pad;
  logic [7:0] o_rx_byte;
  logic       o_rx_dv;
  logic       o_frame_err;
  logic       o_hl_rx_active;
  logic       o_cmd_start;

  // Receiver side: samples the pad and drives the decoded results
  modport slave (
    input  i_rx_pad,
    output o_rx_byte, o_rx_dv, o_frame_err, o_hl_rx_active, o_cmd_start
  );

  // Host side: drives the pad and consumes the decoded results
  modport master (
    output i_rx_pad,
    input  o_rx_byte, o_rx_dv, o_frame_err, o_hl_rx_active, o_cmd_start
  );
endinterface

// File: rtl/uart_rx_cmd.sv
// Serial command receiver for the frequency counter host link.
// Deserialises 8N1 frames, strobes out every good byte and raises a
// one-cycle start request when the text "measure" followed by CR arrives.
module uart_rx_cmd #(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic         clk,
  input  logic         i_Rst_L,
  uart_rx_cmd_if.slave bus
);

  localparam int H  = (CLKS_PER_BIT - 1) / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);

  // Full bit period for data and stop bits.
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
  // START is entered one cycle after the falling edge is seen, so the
  // counter only needs to reach H-1 for the start sample to sit H cycles
  // after the edge; every later sample is then one full period apart.
  localparam logic [CW-1:0] START_LAST = CW'(H - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  rx_state_t     state;
  logic          rx_meta;
  logic          rxs;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic [7:0]    rx_byte;
  logic          rx_dv;
  logic          frame_err;
  logic          rx_active;
  logic [2:0]    match_idx;
  logic          cmd_start;

  // Command text "measure\r", one byte per match position.
  function automatic logic [7:0] pattern_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    pattern_byte = 8'h6D;
      3'd1:    pattern_byte = 8'h65;
      3'd2:    pattern_byte = 8'h61;
      3'd3:    pattern_byte = 8'h73;
      3'd4:    pattern_byte = 8'h75;
      3'd5:    pattern_byte = 8'h72;
      3'd6:    pattern_byte = 8'h65;
      default: pattern_byte = 8'h0D;
    endcase
  endfunction

  // Two-flop synchroniser for the asynchronous pad, idling high
  always_ff @(posedge clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= bus.i_rx_pad;
      rxs     <= rx_meta;
    end
  end

  // Frame receiver: mid-bit sampling, byte/error strobes, busy flag
  always_ff @(posedge clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
      rx_byte   <= 8'h00;
      rx_dv     <= 1'b0;
      frame_err <= 1'b0;
      rx_active <= 1'b0;
    end else begin
      rx_dv     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state     <= START;
            clk_cnt   <= '0;
            rx_active <= 1'b1;
          end
        end
        START: begin
          if (clk_cnt == START_LAST) begin
            clk_cnt <= '0;
            if (!rxs) begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end else begin
              state     <= IDLE;
              rx_active <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt   <= '0;
            shift_reg <= {rxs, shift_reg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt   <= '0;
            rx_active <= 1'b0;
            if (rxs) begin
              rx_byte <= shift_reg;
              rx_dv   <= 1'b1;
              state   <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rxs) begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          rx_active <= 1'b0;
        end
      endcase
    end
  end

  // Command matcher: tracks progress through "measure\r" on each good byte
  always_ff @(posedge clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      match_idx <= 3'd0;
      cmd_start <= 1'b0;
    end else begin
      cmd_start <= 1'b0;
      if (frame_err) begin
        match_idx <= 3'd0;
      end else if (rx_dv) begin
        if (rx_byte == pattern_byte(match_idx)) begin
          if (match_idx == 3'd7) begin
            cmd_start <= 1'b1;
            match_idx <= 3'd0;
          end else begin
            match_idx <= match_idx + 3'd1;
          end
        end else if (rx_byte == 8'h6D) begin
          match_idx <= 3'd1;
        end else begin
          match_idx <= 3'd0;
        end
      end
    end
  end

  assign bus.o_rx_byte      = rx_byte;
  assign bus.o_rx_dv        = rx_dv;
  assign bus.o_frame_err    = frame_err;
  assign bus.o_hl_rx_active = rx_active;
  assign bus.o_cmd_start    = cmd_start;

endmodule

// File: tb/tb_uart_rx_cmd.sv
// Self-checking bench for uart_rx_cmd: bit-banged frames with controlled
// baud skew, checked against a byte-stream model of the receiver.
module tb_uart_rx_cmd;

  localparam int CPB = 16;
  localparam logic [63:0] CMD_WORD = 64'h6D6561737572650D;

  logic        clk = 1'b0;
  logic        i_Rst_L = 1'b0;
  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  uart_rx_cmd_if bus();

  uart_rx_cmd #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .i_Rst_L (i_Rst_L),
    .bus     (bus)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  // Free-running edge counter used as the timing reference
  always @(posedge clk) cyc <= cyc + 1;

  // Compare one observed value against the expected one and tally it
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Monitor state: collected bytes, strobe counts, edge timestamps
  logic [7:0]  got_q[$];
  int          got_cmd = 0;
  int          got_ferr = 0;
  int unsigned dv_cyc = 0;
  int unsigned rise_cyc = 0;
  int unsigned act_fall_cyc = 0;
  logic        prev_active = 1'b0;

  // Watch the outputs mid-cycle and record every strobe and busy edge
  always @(negedge clk) begin
    if (bus.o_rx_dv || bus.o_frame_err)
      checkOutput("strobe_exclusive", {31'd0, bus.o_rx_dv & bus.o_frame_err}, 32'd0);
    if (bus.o_cmd_start) begin
      got_cmd++;
      checkOutput("cmd_latency", cyc - dv_cyc, 32'd1);
    end
    if (bus.o_rx_dv) begin
      got_q.push_back(bus.o_rx_byte);
      dv_cyc = cyc;
    end
    if (bus.o_frame_err) got_ferr++;
    if (bus.o_hl_rx_active && !prev_active) rise_cyc = cyc;
    if (!bus.o_hl_rx_active && prev_active) act_fall_cyc = cyc;
    prev_active = bus.o_hl_rx_active;
  end

  // Reference model: expected bytes, last good byte, and the last eight
  // bytes since reset/frame error, which signal a command when they spell it
  logic [7:0]  exp_q[$];
  int          exp_cmd = 0;
  int          exp_ferr = 0;
  logic [63:0] hist = '0;
  logic [7:0]  exp_last = 8'h00;
  int unsigned last_fall = 0;

  task automatic model_good(input logic [7:0] b);
    exp_q.push_back(b);
    exp_last = b;
    hist = {hist[55:0], b};
    if (hist == CMD_WORD) begin
      exp_cmd++;
      hist = '0;
    end
  endtask

  task automatic model_bad();
    exp_ferr++;
    hist = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Bit-bang one frame; bit j starts round(j*period/100) edges after the
  // falling edge, so period_x100 of 1552/1648 is a 3% fast/slow transmitter
  task automatic drive_frame(input logic [7:0] data, input logic stop_bit,
                             input int period_x100);
    logic [9:0] bits;
    int prev_b;
    int next_b;
    bits   = {stop_bit, data, 1'b0};
    prev_b = 0;
    #1;
    last_fall = cyc;
    for (int j = 0; j < 10; j++) begin
      bus.i_rx_pad = bits[j];
      next_b = ((j + 1) * period_x100 + 50) / 100;
      repeat (next_b - prev_b) @(posedge clk);
      prev_b = next_b;
      if (j < 9) #1;
    end
  endtask

  // Send a frame and update the model; a bad stop bit is followed by the
  // line held low for hold_low extra cycles before it returns high
  task automatic applyStimulus(input logic [7:0] data, input logic stop_ok,
                               input int period_x100, input int hold_low);
    drive_frame(data, stop_ok, period_x100);
    if (stop_ok) begin
      model_good(data);
    end else begin
      model_bad();
      repeat (hold_low) @(posedge clk);
      #1 bus.i_rx_pad = 1'b1;
      idle(3);
    end
  endtask

  task automatic send_text(input string s, input int period_x100);
    for (int i = 0; i < s.len(); i++) applyStimulus(s[i], 1'b1, period_x100, 0);
  endtask

  // Settle, then compare the collected stream and counters with the model
  task automatic check_stream(input string tag);
    idle(6);
    checkOutput({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      checkOutput({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
    checkOutput({tag, "_cmd"}, got_cmd, exp_cmd);
    checkOutput({tag, "_ferr"}, got_ferr, exp_ferr);
    checkOutput({tag, "_held_byte"}, bus.o_rx_byte, exp_last);
  endtask

  // Hard stop in case anything stalls
  initial begin
    #950000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence
  initial begin
    logic [63:0] cmd_bytes;
    int unsigned f;
    cmd_bytes    = CMD_WORD;
    bus.i_rx_pad = 1'b1;
    i_Rst_L      = 1'b0;
    idle(5);
    checkOutput("rst_rx_byte", bus.o_rx_byte, 32'h00);
    checkOutput("rst_rx_dv", bus.o_rx_dv, 32'd0);
    checkOutput("rst_frame_err", bus.o_frame_err, 32'd0);
    checkOutput("rst_active", bus.o_hl_rx_active, 32'd0);
    checkOutput("rst_cmd_start", bus.o_cmd_start, 32'd0);
    #3 i_Rst_L = 1'b1;
    idle(5);

    // Single byte with ideal timing: strobe and busy-window placement
    applyStimulus(8'hA5, 1'b1, 1600, 0);
    f = last_fall;
    idle(10);
    checkOutput("a5_dv_time", dv_cyc - f, 32'd154);
    checkOutput("a5_active_rise", rise_cyc - f, 32'd3);
    checkOutput("a5_active_fall", act_fall_cyc - f, 32'd154);
    check_stream("a5");

    // Back-to-back command, twice
    send_text("measure\r", 1600);
    send_text("measure\r", 1600);
    check_stream("cmd_x2");

    // Restart on a repeated leading 'm', and near-misses
    send_text("mmeasure\r", 1600);
    check_stream("cmd_mm");
    send_text("measure\n\r", 1600);
    check_stream("cmd_lf");
    send_text("Measure\r", 1600);
    check_stream("cmd_case");

    // Bad stop bit, line held low, then a clean command
    drive_frame(8'h55, 1'b0, 1600);
    model_bad();
    for (int k = 0; k < 4; k++) begin
      idle(10);
      checkOutput("break_inactive", bus.o_hl_rx_active, 32'd0);
    end
    checkOutput("break_no_dv", got_q.size(), 32'd0);
    checkOutput("break_ferr", got_ferr, exp_ferr);
    checkOutput("break_held_byte", bus.o_rx_byte, exp_last);
    #1 bus.i_rx_pad = 1'b1;
    idle(3);
    send_text("measure\r", 1600);
    check_stream("break_recover");

    // Short low glitch is rejected at the start sample
    idle(2);
    #1;
    f = cyc;
    bus.i_rx_pad = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.i_rx_pad = 1'b1;
    idle(20);
    checkOutput("glitch_active_rise", rise_cyc - f, 32'd3);
    checkOutput("glitch_active_fall", act_fall_cyc - f, 32'd10);
    check_stream("glitch");

    // Reset in the middle of a command aborts frame and match progress
    send_text("meas", 1600);
    fork
      drive_frame(8'h75, 1'b1, 1600);
      begin
        idle(70);
        #3 i_Rst_L = 1'b0;
        idle(2);
        checkOutput("midrst_active", bus.o_hl_rx_active, 32'd0);
        checkOutput("midrst_rx_byte", bus.o_rx_byte, 32'h00);
        idle(100);
        #3 i_Rst_L = 1'b1;
      end
    join
    hist     = '0;
    exp_last = 8'h00;
    idle(4);
    send_text("ure\r", 1600);
    check_stream("midrst");

    // 3% fast and 3% slow transmitter
    applyStimulus(8'h3C, 1'b1, 1552, 0);
    check_stream("skew_fast");
    applyStimulus(8'h3C, 1'b1, 1648, 0);
    check_stream("skew_slow");

    // Randomised mix of commands, fragments, noise bytes and bad frames
    for (int n = 0; n < 40; n++) begin
      int kind;
      int per;
      int k;
      kind = $urandom_range(0, 9);
      per  = 1552 + $urandom_range(0, 96);
      k    = $urandom_range(0, 7);
      case (kind)
        0, 1:    send_text("measure\r", per);
        2:       applyStimulus(8'h6D, 1'b1, per, 0);
        3:       applyStimulus(8'($urandom_range(0, 255)), 1'b0, per, $urandom_range(0, 30));
        4, 5, 6: applyStimulus(cmd_bytes[8*k +: 8], 1'b1, per, 0);
        default: applyStimulus(8'($urandom_range(0, 255)), 1'b1, per, 0);
      endcase
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 12));
    end
    check_stream("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
